// File: rtl/alu_arbiter.sv
// Two-requester front end to one shared 4-bit ALU with a single-entry response register.
// Round-robin or fixed-priority arbitration; results appear the cycle after acceptance.
module alu_arbiter #(
    parameter bit FAIR = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [2:0] req0_op,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [2:0] req1_op,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    output logic       req1_ready,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_y,
    output logic       rsp_c
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    typedef struct packed {
        logic       id;
        logic [3:0] y;
        logic       c;
    } rsp_t;

    state_t     state, state_n;
    rsp_t       rsp_q;
    logic       ptr;
    logic       win;
    logic       slot_free;
    logic       accept;
    logic [2:0] op_sel;
    logic [3:0] a_sel, b_sel;
    logic [4:0] res;

    // Bit 4 carries add carry-out or sub borrow; zero for logic ops.
    function automatic logic [4:0] alu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            3'b000:  alu = {1'b0, a} + {1'b0, b};
            3'b001:  alu = {a < b, a - b};
            3'b010:  alu = {1'b0, a & b};
            3'b011:  alu = {1'b0, a | b};
            3'b100:  alu = {1'b0, a ^ b};
            3'b101:  alu = {1'b0, ~(a ^ b)};
            3'b110:  alu = {1'b0, ~(a & b)};
            3'b111:  alu = {1'b0, ~(a | b)};
            default: alu = 5'd0;
        endcase
    endfunction

    assign slot_free = (state == EMPTY) || rsp_ready;

    // win = index of the requester that would be granted; a lone requester always wins.
    always_comb begin
        win = req1_valid;
        if (req0_valid && req1_valid)
            win = FAIR ? ptr : 1'b0;
    end

    // Reset gating keeps readies low even though EMPTY makes the slot look free.
    assign req0_ready = !rst && slot_free && req0_valid && !win;
    assign req1_ready = !rst && slot_free && req1_valid && win;
    assign accept     = req0_ready || req1_ready;

    assign op_sel = win ? req1_op : req0_op;
    assign a_sel  = win ? req1_a  : req0_a;
    assign b_sel  = win ? req1_b  : req0_b;
    assign res    = alu(op_sel, a_sel, b_sel);

    always_comb begin
        state_n = state;
        case (state)
            EMPTY:   if (accept) state_n = FULL;
            FULL:    if (rsp_ready) state_n = accept ? FULL : EMPTY;
            default: state_n = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            ptr   <= 1'b0;
            rsp_q <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                rsp_q <= '{id: req1_ready, y: res[3:0], c: res[4]};
                if (FAIR)
                    ptr <= !req1_ready;
            end
        end
    end

    assign rsp_valid = (state == FULL);
    assign rsp_id    = rsp_q.id;
    assign rsp_y     = rsp_q.y;
    assign rsp_c     = rsp_q.c;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: table-driven vectors with a result scoreboard, random lone requests,
// and directed reset / round-robin sequences against FAIR=1 and FAIR=0 instances.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
    logic [2:0] req0_op = '0, req1_op = '0;
    logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic       req0_ready, req1_ready, rsp_valid, rsp_id, rsp_c;
    logic [3:0] rsp_y;
    logic       f_req0_ready, f_req1_ready, f_rsp_valid, f_rsp_id, f_rsp_c;
    logic [3:0] f_rsp_y;

    always #5 clk = ~clk;

    alu_arbiter #(.FAIR(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_c(rsp_c)
    );

    alu_arbiter #(.FAIR(1'b0)) dut_fix (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(f_req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(f_req1_ready),
        .rsp_valid(f_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(f_rsp_id), .rsp_y(f_rsp_y), .rsp_c(f_rsp_c)
    );

    typedef struct packed {
        logic       v0;
        logic [2:0] op0;
        logic [3:0] a0, b0;
        logic       v1;
        logic [2:0] op1;
        logic [3:0] a1, b1;
        logic       rr;
        logic       er0, er1;
        logic       eid;
        logic [3:0] ey;
        logic       ec;
    } vec_t;

    typedef struct packed {
        logic       id;
        logic [3:0] y;
        logic       c;
    } res_t;

    vec_t tbl[$];
    res_t sbq[$];
    res_t held;
    logic exp_valid;
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic v0, input int op0, input int a0, input int b0,
                                input logic v1, input int op1, input int a1, input int b1,
                                input logic rr, input logic er0, input logic er1,
                                input logic eid, input int ey, input logic ec);
        vec_t v;
        v.v0 = v0; v.op0 = 3'(op0); v.a0 = 4'(a0); v.b0 = 4'(b0);
        v.v1 = v1; v.op1 = 3'(op1); v.a1 = 4'(a1); v.b1 = 4'(b1);
        v.rr = rr; v.er0 = er0; v.er1 = er1; v.eid = eid; v.ey = 4'(ey); v.ec = ec;
        return v;
    endfunction

    // Reference ALU written in integer arithmetic, independent of the RTL bit tricks.
    function automatic res_t alu_ref(input logic id, input int op, input int a, input int b);
        res_t r;
        int   s;
        r.id = id;
        r.c  = 1'b0;
        case (op)
            0: begin s = a + b; r.y = 4'(s % 16); r.c = (s > 15); end
            1: begin s = a - b; r.y = 4'((s + 16) % 16); r.c = (a < b); end
            2: r.y = 4'(a & b);
            3: r.y = 4'(a | b);
            4: r.y = 4'(a ^ b);
            5: r.y = 4'(15 - (a ^ b));
            6: r.y = 4'(15 - (a & b));
            default: r.y = 4'(15 - (a | b));
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, wanted %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive at negedge, check readies before the edge, check response after it.
    task automatic apply(input vec_t v);
        req0_valid = v.v0; req0_op = v.op0; req0_a = v.a0; req0_b = v.b0;
        req1_valid = v.v1; req1_op = v.op1; req1_a = v.a1; req1_b = v.b1;
        rsp_ready  = v.rr;
        #1;
        chk("req0_ready", int'(req0_ready), int'(v.er0));
        chk("req1_ready", int'(req1_ready), int'(v.er1));
        if (v.er0 || v.er1)
            sbq.push_back('{id: v.eid, y: v.ey, c: v.ec});
        @(posedge clk);
        #1;
        if (v.er0 || v.er1) begin
            held = sbq.pop_front();
            exp_valid = 1'b1;
        end else if (v.rr) begin
            exp_valid = 1'b0;
        end
        chk("rsp_valid", int'(rsp_valid), int'(exp_valid));
        if (exp_valid) begin
            chk("rsp_id", int'(rsp_id), int'(held.id));
            chk("rsp_y", int'(rsp_y), int'(held.y));
            chk("rsp_c", int'(rsp_c), int'(held.c));
        end
        @(negedge clk);
    endtask

    initial begin
        exp_valid = 1'b0;
        held = '0;

        // Reset asserted with no clock edge yet.
        #1 rst = 1'b1;
        req0_valid = 1'b1;
        #1;
        chk("rst_valid", int'(rsp_valid), 0);
        chk("rst_id", int'(rsp_id), 0);
        chk("rst_y", int'(rsp_y), 0);
        chk("rst_c", int'(rsp_c), 0);
        chk("rst_ready0", int'(req0_ready), 0);
        req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        //               v0 op a  b   v1 op a  b   rr er0 er1 id  y  c
        tbl.push_back(mk(1, 0, 7, 5,  0, 0, 0, 0,  1, 1, 0,  0, 12, 0));
        tbl.push_back(mk(0, 3, 1, 1,  1, 0, 9, 9,  1, 0, 1,  1,  2, 1));
        tbl.push_back(mk(0, 0, 0, 0,  1, 1, 3, 5,  1, 0, 1,  1, 14, 1));
        tbl.push_back(mk(1, 2, 12, 10, 0, 7, 5, 5, 1, 1, 0,  0,  8, 0));
        tbl.push_back(mk(1, 3, 12, 10, 0, 0, 0, 0, 1, 1, 0,  0, 14, 0));
        tbl.push_back(mk(1, 4, 12, 10, 0, 0, 0, 0, 1, 1, 0,  0,  6, 0));
        tbl.push_back(mk(1, 5, 12, 10, 0, 0, 0, 0, 1, 1, 0,  0,  9, 0));
        tbl.push_back(mk(1, 6, 12, 10, 0, 0, 0, 0, 1, 1, 0,  0,  7, 0));
        tbl.push_back(mk(1, 7, 12, 10, 0, 0, 0, 0, 1, 1, 0,  0,  1, 0));
        tbl.push_back(mk(1, 1, 9, 3,  0, 0, 0, 0,  1, 1, 0,  0,  6, 0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1, 0, 1, 1, 1, 0, 2, 2, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1,  1, 0, 2, 2,  1, 0, 1,  1,  4, 0));
        tbl.push_back(mk(1, 0, 1, 1,  1, 0, 2, 2,  1, 1, 0,  0,  2, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0,  0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0,  1, 0, 0,  0,  0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0,  0,  0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  1, 0, 15, 1, 0, 0, 1,  1,  0, 1));
        tbl.push_back(mk(1, 4, 15, 5, 0, 0, 0, 0,  0, 0, 0,  0,  0, 0));
        tbl.push_back(mk(1, 4, 15, 5, 0, 0, 0, 0,  1, 1, 0,  0, 10, 0));

        foreach (tbl[i])
            apply(tbl[i]);

        // Random lone requests; the idle requester carries junk that must be ignored.
        for (int i = 0; i < 16; i++) begin
            int   op, a, b;
            logic r;
            res_t e;
            r  = 1'($urandom_range(0, 1));
            op = int'($urandom_range(0, 7));
            a  = int'($urandom_range(0, 15));
            b  = int'($urandom_range(0, 15));
            e  = alu_ref(r, op, a, b);
            if (r)
                apply(mk(0, 7 - op, b, a, 1, op, a, b, 1, 0, 1, 1, int'(e.y), e.c));
            else
                apply(mk(1, op, a, b, 0, 7 - op, b, a, 1, 1, 0, 0, int'(e.y), e.c));
        end

        // Leave a result from requester 0 held, so the pointer prefers requester 1.
        apply(mk(1, 0, 1, 2, 0, 0, 0, 0, 1, 1, 0, 0, 3, 0));
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", int'(rsp_valid), 0);
        chk("midrst_y", int'(rsp_y), 0);
        chk("midrst_ready0", int'(req0_ready), 0);
        chk("midrst_ready1", int'(req1_ready), 0);
        chk("midrst_fix_valid", int'(f_rsp_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        exp_valid = 1'b0;
        sbq.delete();

        // Nothing requested after release: the discarded result must not reappear.
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("postrst_valid", int'(rsp_valid), 0);
        @(negedge clk);

        // Both valid every cycle: FAIR=1 alternates from 0, FAIR=0 always grants 0.
        req0_valid = 1'b1; req0_op = 3'b000; req0_a = 4'd1; req0_b = 4'd1;
        req1_valid = 1'b1; req1_op = 3'b000; req1_a = 4'd2; req1_b = 4'd2;
        rsp_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int g;
            g = i % 2;
            #1;
            chk("rr_ready0", int'(req0_ready), int'(g == 0));
            chk("rr_ready1", int'(req1_ready), int'(g == 1));
            chk("fix_ready0", int'(f_req0_ready), 1);
            chk("fix_ready1", int'(f_req1_ready), 0);
            @(posedge clk);
            #1;
            chk("rr_id", int'(rsp_id), g);
            chk("rr_y", int'(rsp_y), (g == 1) ? 4 : 2);
            chk("fix_id", int'(f_rsp_id), 0);
            chk("fix_y", int'(f_rsp_y), 2);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: FAIR, 1, 1 = round-robin grant between requesters; 0 = fixed priority to requester 0.
REQ-002 The block SHALL provide one clock, clk, and the reset is asynchronous and active-high, rst.
REQ-003 Ports SHALL be:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous active-high reset
- req0_valid  input  1  requester 0 has an operation
- req0_op  input  3  requester 0 opcode (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 xnor, 110 nand, 111 nor)
- req0_a  input  4  requester 0 operand A
- req0_b  input  4  requester 0 operand B
- req0_ready  output  1  requester 0 accepted this cycle
- req1_valid, req1_op, req1_a, req1_b, req1_ready  same widths and meanings for requester 1
- rsp_valid  output  1  response register holds a result
- rsp_ready  input  1  consumer accepts the response
- rsp_id  output  1  requester index of the held result
- rsp_y  output  4  4-bit ALU result
- rsp_c  output  1  add carry-out / sub borrow; 0 for logic ops

Function
REQ-004 The block SHALL contain one shared 4-bit ALU implementing the eight opcodes in REQ-003, and a single response register.
REQ-005 Slot-free condition: slot_free = !rsp_valid || rsp_ready.
REQ-006 A request SHALL be accepted (reqN_ready=1) only in a cycle where reqN_valid=1, slot_free=1 and N wins arbitration; reqN_ready SHALL be combinational from these terms.
REQ-007 At most one reqN_ready SHALL be high per cycle; reqN_ready SHALL be 0 whenever reqN_valid=0.
REQ-008 Arbitration with FAIR=1: a 1-bit pointer (reset 0) names the preferred requester. If both are valid, the preferred requester wins. After any grant, the pointer SHALL point to the non-granted index. A lone valid requester SHALL win regardless of the pointer.
REQ-009 With FAIR=0, requester 0 SHALL always win when both are valid, and the pointer is unused.
REQ-010 Latency: on acceptance at edge N, rsp_valid, rsp_id, rsp_y and rsp_c SHALL be presented from edge N onward, i.e. visible in the cycle after the handshake.
REQ-011 Throughput: one result per cycle while rsp_ready=1 and a requester is valid.
REQ-012 The response register SHALL have two states:
- EMPTY (rsp_valid=0): goes to FULL on acceptance, otherwise stays EMPTY.
- FULL (rsp_valid=1):
  - rsp_ready=1 with a new acceptance: load the new result and stay FULL.
  - rsp_ready=1 without acceptance: go to EMPTY.
  - rsp_ready=0: hold rsp_id, rsp_y and rsp_c unchanged.
REQ-013 Arithmetic:
- add: {rsp_c, rsp_y} = A + B, computed at 5 bits.
- sub: rsp_y = (A - B) mod 16, and rsp_c = 1 iff A < B (unsigned).
- logic ops: rsp_c = 0.
REQ-014 Operands and opcode SHALL be sampled only on the accepting edge; changes to a requester's inputs while it is not granted SHALL have no effect.
REQ-015 Under backpressure (rsp_ready=0, FULL), both reqN_ready SHALL be 0, and the pointer SHALL not change.
REQ-016 X/undefined opcodes are not a legal input; no default-case behaviour is verified beyond a result of 0.

Reset
REQ-017 While rst=1, independent of clk, the block SHALL drive: rsp_valid=0, rsp_id=0, rsp_y=0, rsp_c=0, pointer=0, state EMPTY.
REQ-018 A result held at reset assertion SHALL be discarded and never presented afterwards.
REQ-019 reqN_ready SHALL be 0 while rst=1.

Verification
REQ-020 Add with no carry: req0 op=000 A=7 B=5, rsp_ready=1 -> next cycle rsp_valid=1, id=0, y=12, c=0.
REQ-021 Add overflow and sub borrow: req1 op=000 A=9 B=9 -> y=2, c=1, id=1. Then op=001 A=3 B=5 -> y=14, c=1.
REQ-022 Round-robin (FAIR=1): both valid every cycle, rsp_ready=1 from reset -> grants in order 0,1,0,1. With FAIR=0 the same stimulus -> all grants to 0.
REQ-023 Backpressure: hold rsp_ready=0 after a result y=6 -> rsp_y stays 6 and both readies stay 0 for 5 cycles. On rsp_ready=1, a waiting request is accepted in that same cycle.
REQ-024 Reset mid-operation: assert rst between edges while FULL -> rsp_valid drops immediately, with no clock edge. After release, the first grant with both valid goes to requester 0.
REQ-025 Logic sweep: for A=4'b1100 B=4'b1010, opcodes 010..111 -> y = 1000, 1110, 0110, 1001, 0111, 0001, each with c=0.
